sha256_msg_schedule: RTL

- SHA-256 message-schedule unit in the Versat datapath.
- Takes the 16 big-endian words of one 512-bit block as a one-word-per-cycle stream.
- Produces W0..W63 one word per cycle.
- out0 feeds the compression-round unit's W input (in8); delay0 is set so that W_t reaches that unit in the same cycle as round t.

---
 rtl/sha256_msg_schedule.sv | 96 +++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: streams in M0..M15 and emits W0..W63, one word per cycle.
// Build option MSG_SCHED_BSWAP_EN byte-reverses in0 for little-endian message sources.
module sha256_msg_schedule #(
  parameter int DELAY_W = 10,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic              done,
  input  logic [7:0]        delay0
);

  typedef enum logic [1:0] {IDLE, DELAY, LOAD, EXPAND} state_t;

  state_t             state;
  logic [5:0]         t;
  logic [DELAY_W-1:0] delay;
  logic               fin;
  logic [DATA_W-1:0]  win [16];

  logic [DATA_W-1:0]  word_in;
  logic [DATA_W-1:0]  w_exp;
  logic [DATA_W-1:0]  next_word;
  logic               load_now;
  logic               adv;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef MSG_SCHED_BSWAP_EN
  assign word_in = {in0[7:0], in0[15:8], in0[23:16], in0[31:24]};
`else
  assign word_in = in0;
`endif

  // win[k] holds W(t-1-k); the sum wraps mod 2^DATA_W
  assign w_exp = sig1(win[1]) + win[6] + sig0(win[14]) + win[15];

  // The last DELAY cycle doubles as the first LOAD cycle
  assign load_now  = (state == LOAD) || ((state == DELAY) && (delay == '0));
  assign adv       = !run && (load_now || (state == EXPAND));
  assign next_word = load_now ? word_in : w_exp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      delay <= '0;
      out0  <= '0;
      done  <= 1'b0;
      fin   <= 1'b0;
      for (int k = 0; k < 16; k++) win[k] <= '0;
    end else begin
      done <= fin;
      fin  <= 1'b0;
      if (run) begin
        delay <= DELAY_W'(delay0);
        t     <= '0;
        done  <= 1'b0;
        state <= DELAY;
      end else begin
        if ((state == DELAY) && (delay != '0)) delay <= delay - 1'b1;
        if (adv) begin
          out0   <= next_word;
          win[0] <= next_word;
          for (int k = 1; k < 16; k++) win[k] <= win[k-1];
          t      <= t + 1'b1;
        end
        case (state)
          DELAY:   if (delay == '0) state <= LOAD;
          LOAD:    if (t == 6'd15) state <= EXPAND;
          EXPAND: begin
            if (t == 6'd63) begin
              state <= IDLE;
              fin   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
